// File: rtl/apb_pkg.sv
// apb_pkg: APB master FSM state type and default bus widths
package apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first req at or after ptr (req, ptr, en -> one-hot gnt, binary idx)
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx
);
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (en && req[(int'(ptr) + k) % N_REQ]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % N_REQ] = 1'b1;
        idx = IW'((int'(ptr) + k) % N_REQ);
      end
  end
endmodule

// File: rtl/apb_rr_master.sv
// apb_rr_master: round-robin APB master (req_* valid/ready in, rsp_* one-cycle pulse out, PSEL1/PENABLE/PWRITE/PADDR/PWDATA out, PRDATA/PREADY/PSLVERR in) with ACCESS watchdog
module apb_rr_master
  import apb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_write,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic                    PSEL1,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_W-1:0]       PADDR,
  output logic [DATA_W-1:0]       PWDATA,
  input  logic [DATA_W-1:0]       PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
  apb_state_e state;
  logic [IW-1:0] ptr, idx, idx_q;
  logic [CW-1:0] cnt;
  logic tmo;
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req(req_valid),
    .ptr(ptr),
    .en(state == IDLE && !rst),
    .gnt(req_ready),
    .idx(idx)
  );
  assign tmo = TIMEOUT_CYC != 0 && cnt == CW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      idx_q     <= '0;
      cnt       <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PSEL1     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
    end else begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (|req_ready) begin
            idx_q  <= idx;
            ptr    <= idx == IW'(N_REQ - 1) ? '0 : idx + 1'b1;
            PWRITE <= req_write[idx];
            PADDR  <= req_addr[int'(idx)*ADDR_W +: ADDR_W];
            PWDATA <= req_wdata[int'(idx)*DATA_W +: DATA_W];
            PSEL1  <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (PREADY || tmo) begin
            state            <= IDLE;
            PSEL1            <= 1'b0;
            PENABLE          <= 1'b0;
            rsp_valid[idx_q] <= 1'b1;
            rsp_err          <= PREADY ? PSLVERR : 1'b1;
            rsp_rdata        <= PREADY && !PWRITE ? PRDATA : '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
